systolic_clk_rst_sequencer: RTL and testbench

//  Power-up/power-down sequencer for the systolic array's per-row clock gates and resets.

---
 rtl/systolic_clk_rst_sequencer.sv | 172 +++++++++++++++++
 tb/tb_systolic_clk_rst_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_clk_rst_sequencer.sv
// Power-up/power-down sequencer for the systolic array's per-row clock gates and resets.
// Staggers row clock enables and reset releases, and drains in-flight data before gating.
module systolic_clk_rst_sequencer #(
  parameter int unsigned NUM_ROWS        = 4,
  parameter int unsigned STAGGER_CYCLES  = 2,
  parameter int unsigned RST_HOLD_CYCLES = 8,
  parameter int unsigned DRAIN_CYCLES    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwr_up_req,
  input  logic                pwr_dn_req,
  input  logic                busy_in,
  output logic [NUM_ROWS-1:0] row_clk_en,
  output logic [NUM_ROWS-1:0] row_rst_n,
  output logic                ready,
  output logic                up_done,
  output logic                dn_done,
  output logic [2:0]          state_o
);

  localparam int unsigned MaxSh  = (STAGGER_CYCLES > RST_HOLD_CYCLES) ? STAGGER_CYCLES
                                                                       : RST_HOLD_CYCLES;
  localparam int unsigned MaxCnt = (MaxSh > DRAIN_CYCLES) ? MaxSh : DRAIN_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

  localparam logic [CntW-1:0] StaggerLast = CntW'(STAGGER_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast    = CntW'(RST_HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] DrainLast   = CntW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    StOff     = 3'd0,
    StClkOn   = 3'd1,
    StHold    = 3'd2,
    StRelease = 3'd3,
    StActive  = 3'd4,
    StDrain   = 3'd5,
    StGate    = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_ROWS-1:0] row_clk_en_q, row_clk_en_d;
  logic [NUM_ROWS-1:0] row_rst_n_q, row_rst_n_d;
  logic                ready_q, ready_d;
  logic                up_done_q, up_done_d;
  logic                dn_done_q, dn_done_d;

  // Rows are enabled/released by shifting a 1 in from row 0, and gated by shifting the
  // enable vector down, so the highest row drops first.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_clk_en_d = row_clk_en_q;
    row_rst_n_d  = row_rst_n_q;
    ready_d      = ready_q;
    up_done_d    = 1'b0;
    dn_done_d    = 1'b0;

    case (state_q)
      StOff: begin
        ready_d = 1'b0;
        if (pwr_up_req) begin
          state_d      = StClkOn;
          cnt_d        = '0;
          row_clk_en_d = NUM_ROWS'(1);
        end
      end
      StClkOn: begin
        if (cnt_q == StaggerLast) begin
          cnt_d = '0;
          if (&row_clk_en_q) begin
            state_d = StHold;
          end else begin
            row_clk_en_d = NUM_ROWS'({row_clk_en_q, 1'b1});
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d     = StRelease;
          cnt_d       = '0;
          row_rst_n_d = NUM_ROWS'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        if (cnt_q == StaggerLast) begin
          cnt_d = '0;
          if (&row_rst_n_q) begin
            state_d   = StActive;
            ready_d   = 1'b1;
            up_done_d = 1'b1;
          end else begin
            row_rst_n_d = NUM_ROWS'({row_rst_n_q, 1'b1});
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StActive: begin
        if (pwr_dn_req) begin
          state_d = StDrain;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      StDrain: begin
        // Any busy cycle restarts the idle run; no way back to ACTIVE from here.
        if (busy_in) begin
          cnt_d = '0;
        end else if (cnt_q == DrainLast) begin
          state_d     = StGate;
          cnt_d       = '0;
          row_rst_n_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGate: begin
        if (cnt_q == StaggerLast) begin
          cnt_d        = '0;
          row_clk_en_d = row_clk_en_q >> 1;
          if (row_clk_en_q == NUM_ROWS'(1)) begin
            state_d   = StOff;
            dn_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d      = StOff;
        cnt_d        = '0;
        row_clk_en_d = '0;
        row_rst_n_d  = '0;
        ready_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StOff;
      cnt_q        <= '0;
      row_clk_en_q <= '0;
      row_rst_n_q  <= '0;
      ready_q      <= 1'b0;
      up_done_q    <= 1'b0;
      dn_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_clk_en_q <= row_clk_en_d;
      row_rst_n_q  <= row_rst_n_d;
      ready_q      <= ready_d;
      up_done_q    <= up_done_d;
      dn_done_q    <= dn_done_d;
    end
  end

  assign row_clk_en = row_clk_en_q;
  assign row_rst_n  = row_rst_n_q;
  assign ready      = ready_q;
  assign up_done    = up_done_q;
  assign dn_done    = dn_done_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_systolic_clk_rst_sequencer.sv
// Bench for systolic_clk_rst_sequencer: directed scenarios plus randomized traffic, all
// checked against a phase/elapsed-time reference model.
module tb_systolic_clk_rst_sequencer;

  localparam int N = 4;
  localparam int S = 2;
  localparam int H = 8;
  localparam int D = 4;

  localparam int PhOff = 0, PhClkOn = 1, PhHold = 2, PhRelease = 3;
  localparam int PhActive = 4, PhDrain = 5, PhGate = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pwr_up_req = 1'b0;
  logic         pwr_dn_req = 1'b0;
  logic         busy_in = 1'b0;
  logic [N-1:0] row_clk_en;
  logic [N-1:0] row_rst_n;
  logic         ready;
  logic         up_done;
  logic         dn_done;
  logic [2:0]   state_o;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  systolic_clk_rst_sequencer #(
    .NUM_ROWS       (N),
    .STAGGER_CYCLES (S),
    .RST_HOLD_CYCLES(H),
    .DRAIN_CYCLES   (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwr_up_req(pwr_up_req),
    .pwr_dn_req(pwr_dn_req),
    .busy_in   (busy_in),
    .row_clk_en(row_clk_en),
    .row_rst_n (row_rst_n),
    .ready     (ready),
    .up_done   (up_done),
    .dn_done   (dn_done),
    .state_o   (state_o)
  );

  // Reference model: current phase, edges elapsed since entering it, and idle run length.
  int   m_ph, m_t, m_idle;
  logic m_up_done, m_dn_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= PhOff; m_t <= 0; m_idle <= 0; m_up_done <= 1'b0; m_dn_done <= 1'b0;
    end else begin
      m_up_done <= 1'b0;
      m_dn_done <= 1'b0;
      case (m_ph)
        PhOff:     if (pwr_up_req) begin m_ph <= PhClkOn; m_t <= 0; end
        PhClkOn:   if (m_t + 1 == N * S) begin m_ph <= PhHold; m_t <= 0; end
                   else m_t <= m_t + 1;
        PhHold:    if (m_t + 1 == H) begin m_ph <= PhRelease; m_t <= 0; end
                   else m_t <= m_t + 1;
        PhRelease: if (m_t + 1 == N * S) begin m_ph <= PhActive; m_t <= 0; m_up_done <= 1'b1; end
                   else m_t <= m_t + 1;
        PhActive:  if (pwr_dn_req) begin m_ph <= PhDrain; m_idle <= 0; end
        PhDrain:   if (busy_in) m_idle <= 0;
                   else if (m_idle + 1 == D) begin m_ph <= PhGate; m_t <= 0; end
                   else m_idle <= m_idle + 1;
        PhGate:    if (m_t + 1 == N * S) begin m_ph <= PhOff; m_dn_done <= 1'b1; end
                   else m_t <= m_t + 1;
        default:   m_ph <= PhOff;
      endcase
    end
  end

  function automatic logic [2*N+5:0] exp_vec();
    logic [N-1:0] en, rs;
    en = '0;
    rs = '0;
    for (int k = 0; k < N; k++) begin
      case (m_ph)
        PhClkOn:            en[k] = (m_t >= k * S);
        PhHold:             en[k] = 1'b1;
        PhRelease:          begin en[k] = 1'b1; rs[k] = (m_t >= k * S); end
        PhActive, PhDrain:  begin en[k] = 1'b1; rs[k] = 1'b1; end
        PhGate:             en[N-1-k] = (m_t < (k + 1) * S);
        default:            ;
      endcase
    end
    return {en, rs, (m_ph == PhActive), m_up_done, m_dn_done, 3'(m_ph)};
  endfunction

  function automatic logic [2*N+5:0] dut_vec();
    return {row_clk_en, row_rst_n, ready, up_done, dn_done, state_o};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; pwr_up_req = 1'b0; pwr_dn_req = 1'b0; busy_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_vec() !== '0) begin
      n_fail++; $display("FAIL reset_values got=%h exp=0", dut_vec());
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (dut_vec() !== exp_vec() || state_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_power_up();
    int en_rise[N], rs_rise[N], up_edge, up_cnt;
    int exp_en[N] = '{1, 3, 5, 7};
    int exp_rs[N] = '{17, 19, 21, 23};
    for (int k = 0; k < N; k++) begin en_rise[k] = -1; rs_rise[k] = -1; end
    up_edge = -1; up_cnt = 0;
    pwr_up_req = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #1;
      if (e == 1) pwr_up_req = 1'b0;
      busy_in = 1'($urandom_range(0, 1));
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL up_model e=%0d got=%h exp=%h", e, dut_vec(), exp_vec());
      end
      n_cmp++;
      if ((row_rst_n & ~row_clk_en) !== '0) begin
        n_fail++; $display("FAIL up_invariant e=%0d rst_n=%b clk_en=%b", e, row_rst_n, row_clk_en);
      end
      for (int k = 0; k < N; k++) begin
        if (en_rise[k] < 0 && row_clk_en[k]) en_rise[k] = e;
        if (rs_rise[k] < 0 && row_rst_n[k]) rs_rise[k] = e;
      end
      if (up_done) begin up_cnt++; if (up_edge < 0) up_edge = e; end
    end
    busy_in = 1'b0;
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (en_rise[k] != exp_en[k]) begin
        n_fail++; $display("FAIL up_clk_en_rise row=%0d got=%0d exp=%0d", k, en_rise[k], exp_en[k]);
      end
      n_cmp++;
      if (rs_rise[k] != exp_rs[k]) begin
        n_fail++; $display("FAIL up_rst_n_rise row=%0d got=%0d exp=%0d", k, rs_rise[k], exp_rs[k]);
      end
    end
    n_cmp++;
    if (up_edge != 25 || up_cnt != 1 || ready !== 1'b1 || state_o !== 3'd4) begin
      n_fail++;
      $display("FAIL up_done_edge got=%0d/%0d ready=%b st=%0d exp=25/1 ready=1 st=4",
               up_edge, up_cnt, ready, state_o);
    end
  endtask

  task automatic test_power_down();
    int en_fall[N], ready_fall, gate_edge, dn_edge;
    logic [N-1:0] gate_rst;
    int exp_fall[N] = '{13, 11, 9, 7};
    for (int k = 0; k < N; k++) en_fall[k] = -1;
    ready_fall = -1; gate_edge = -1; dn_edge = -1; gate_rst = '1;
    pwr_dn_req = 1'b1; busy_in = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk); #1;
      if (e == 1) pwr_dn_req = 1'b0;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL dn_model e=%0d got=%h exp=%h", e, dut_vec(), exp_vec());
      end
      n_cmp++;
      if ((row_rst_n & ~row_clk_en) !== '0) begin
        n_fail++; $display("FAIL dn_invariant e=%0d rst_n=%b clk_en=%b", e, row_rst_n, row_clk_en);
      end
      if (ready_fall < 0 && !ready) ready_fall = e;
      if (gate_edge < 0 && state_o == 3'd6) begin gate_edge = e; gate_rst = row_rst_n; end
      if (dn_edge < 0 && dn_done) dn_edge = e;
      for (int k = 0; k < N; k++) if (en_fall[k] < 0 && !row_clk_en[k]) en_fall[k] = e;
    end
    n_cmp++;
    if (ready_fall != 1 || gate_edge != 5 || gate_rst !== '0) begin
      n_fail++;
      $display("FAIL dn_drain_gate got ready_fall=%0d gate=%0d rst=%b exp 1/5/0000",
               ready_fall, gate_edge, gate_rst);
    end
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (en_fall[k] != exp_fall[k]) begin
        n_fail++; $display("FAIL dn_clk_en_fall row=%0d got=%0d exp=%0d", k, en_fall[k], exp_fall[k]);
      end
    end
    n_cmp++;
    if (dn_edge != 13 || state_o !== 3'd0) begin
      n_fail++; $display("FAIL dn_done_edge got=%0d st=%0d exp=13 st=0", dn_edge, state_o);
    end
  endtask

  task automatic test_drain_glitch();
    int gate_edge;
    pwr_up_req = 1'b1; busy_in = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #1;
      if (e == 1) pwr_up_req = 1'b0;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL glitch_up_model e=%0d got=%h exp=%h", e, dut_vec(), exp_vec());
      end
    end
    // Idle at edges 2..4, busy at edge 5, then idle: four fresh idle edges 6..9.
    gate_edge = -1;
    pwr_dn_req = 1'b1; busy_in = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      @(posedge clk); #1;
      pwr_dn_req = 1'b0;
      busy_in = (e + 1 == 5);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL glitch_model e=%0d got=%h exp=%h", e, dut_vec(), exp_vec());
      end
      if (gate_edge < 0 && state_o == 3'd6) gate_edge = e;
    end
    n_cmp++;
    if (gate_edge != 9 || state_o !== 3'd0) begin
      n_fail++; $display("FAIL glitch_gate_edge got=%0d st=%0d exp=9 st=0", gate_edge, state_o);
    end
  endtask

  task automatic test_dn_during_up();
    int active_edge, drain_edge;
    active_edge = -1; drain_edge = -1;
    pwr_up_req = 1'b1; busy_in = 1'b0;
    for (int e = 1; e <= 38; e++) begin
      @(posedge clk); #1;
      if (e == 1) pwr_up_req = 1'b0;
      if (e == 9) pwr_dn_req = 1'b1;
      if (e == 26) pwr_dn_req = 1'b0;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL early_dn_model e=%0d got=%h exp=%h", e, dut_vec(), exp_vec());
      end
      if (active_edge < 0 && state_o == 3'd4) active_edge = e;
      if (drain_edge < 0 && state_o == 3'd5) drain_edge = e;
    end
    n_cmp++;
    if (active_edge != 25 || drain_edge != 26 || state_o !== 3'd0) begin
      n_fail++;
      $display("FAIL early_dn_edges got active=%0d drain=%0d st=%0d exp 25/26/0",
               active_edge, drain_edge, state_o);
    end
  endtask

  task automatic test_both_req();
    int st1, active_edge, drain_edge, dn_edge, st_after;
    st1 = -1; active_edge = -1; drain_edge = -1; dn_edge = -1; st_after = -1;
    pwr_up_req = 1'b1; pwr_dn_req = 1'b1; busy_in = 1'b0;
    for (int e = 1; e <= 39; e++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL both_model e=%0d got=%h exp=%h", e, dut_vec(), exp_vec());
      end
      if (e == 1) st1 = int'(state_o);
      if (e == 39) st_after = int'(state_o);
      if (active_edge < 0 && state_o == 3'd4) active_edge = e;
      if (drain_edge < 0 && state_o == 3'd5) drain_edge = e;
      if (dn_edge < 0 && dn_done) dn_edge = e;
    end
    pwr_up_req = 1'b0; pwr_dn_req = 1'b0;
    n_cmp++;
    if (st1 != 1 || active_edge != 25 || drain_edge != 26) begin
      n_fail++;
      $display("FAIL both_up_then_drain got st1=%0d active=%0d drain=%0d exp 1/25/26",
               st1, active_edge, drain_edge);
    end
    n_cmp++;
    if (dn_edge != 38 || st_after != 1) begin
      n_fail++; $display("FAIL both_restart got dn=%0d st=%0d exp 38/1", dn_edge, st_after);
    end
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0; pwr_up_req = 1'b0; pwr_dn_req = 1'b0; busy_in = 1'b0;
    #2 rst_n = 1'b1;
    pwr_up_req = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e == 1) pwr_up_req = 1'b0;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL areset_model e=%0d got=%h exp=%h", e, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (row_rst_n !== 4'b0011 || state_o !== 3'd3) begin
      n_fail++; $display("FAIL areset_pre got rst_n=%b st=%0d exp 0011/3", row_rst_n, state_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== '0) begin
      n_fail++; $display("FAIL areset_immediate got=%h exp=0", dut_vec());
    end
    @(posedge clk); #1;
    n_cmp++;
    if (dut_vec() !== '0) begin
      n_fail++; $display("FAIL areset_held got=%h exp=0", dut_vec());
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rand_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      n_cmp++;
      if ((row_rst_n & ~row_clk_en) !== '0) begin
        n_fail++; $display("FAIL rand_invariant c=%0d rst_n=%b clk_en=%b", c, row_rst_n, row_clk_en);
      end
      pwr_up_req = ($urandom_range(0, 7) == 0);
      pwr_dn_req = ($urandom_range(0, 7) == 0);
      busy_in    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec() !== '0) begin
          n_fail++; $display("FAIL rand_areset c=%0d got=%h exp=0", c, dut_vec());
        end
        rst_n = 1'b1;
      end
    end
    pwr_up_req = 1'b0; pwr_dn_req = 1'b0; busy_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_drain_glitch();
    test_dn_during_up();
    test_both_req();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout compared=%0d mismatched=%0d", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

endmodule
